// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with Valid/Ready load and Busy/Last/Done framing.
// Optional even-parity bit appended after the data bits when PISO_PARITY_EN is defined.
//
// state | meaning
// IDLE  | no frame in flight, Out held low, ready for a word
// SHIFT | a frame bit is on Out; counter holds bits remaining after this one
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] Data,
  input  logic             Valid,
  output logic             Ready,
  output logic             Out,
  output logic             Busy,
  output logic             Last,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
`else
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             done_q, done_d;

  logic             fill_bit;
  logic             load_bit;
  logic [WIDTH-1:0] load_shift;
  logic             nxt_bit;
  logic [WIDTH-1:0] nxt_shift;
  logic             last;
  logic             accept;

  // The parity bit rides in the shift register's vacated end, so it falls out after the data.
`ifdef PISO_PARITY_EN
  assign fill_bit = ^Data;
`else
  assign fill_bit = 1'b0;
`endif

  always_comb begin
    if (LSB_FIRST) begin
      load_bit   = Data[0];
      load_shift = {fill_bit, Data[WIDTH-1:1]};
      nxt_bit    = shift_q[0];
      nxt_shift  = {1'b0, shift_q[WIDTH-1:1]};
    end else begin
      load_bit   = Data[WIDTH-1];
      load_shift = {Data[WIDTH-2:0], fill_bit};
      nxt_bit    = shift_q[WIDTH-1];
      nxt_shift  = {shift_q[WIDTH-2:0], 1'b0};
    end
  end

  assign last   = (state_q == SHIFT) && (cnt_q == '0);
  assign Ready  = (state_q == IDLE) || last;
  assign accept = Valid && Ready;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        out_d = 1'b0;
        if (accept) begin
          state_d = SHIFT;
          shift_d = load_shift;
          out_d   = load_bit;
          cnt_d   = CNT_LOAD;
        end
      end
      SHIFT: begin
        if (last) begin
          done_d = 1'b1;
          if (accept) begin
            shift_d = load_shift;
            out_d   = load_bit;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = IDLE;
            out_d   = 1'b0;
          end
        end else begin
          out_d   = nxt_bit;
          shift_d = nxt_shift;
          cnt_d   = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign Out  = out_q;
  assign Busy = (state_q == SHIFT);
  assign Last = last;
  assign Done = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances plus a 4-bit SIPO loopback.
// Expected frames are written as 5-bit vectors: four data bits in send order, then the parity bit.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic       Clk;
  logic       Rst_n;
  logic [3:0] Data, Data_l;
  logic       Valid, Valid_l;
  logic       Ready, Out, Busy, Last, Done;
  logic       Ready_l, Out_l, Busy_l, Last_l, Done_l;
  logic [3:0] sipo;

  int checks = 0;
  int errors = 0;

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Data(Data), .Valid(Valid), .Ready(Ready),
    .Out(Out), .Busy(Busy), .Last(Last), .Done(Done)
  );

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_lsb (
    .Clk(Clk), .Rst_n(Rst_n), .Data(Data_l), .Valid(Valid_l), .Ready(Ready_l),
    .Out(Out_l), .Busy(Busy_l), .Last(Last_l), .Done(Done_l)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) sipo <= {sipo[2:0], Out};

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", Ready); end
    checks++; if (Out !== 1'b0) begin errors++; $display("FAIL reset_out got %b exp 0", Out); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", Busy); end
    checks++; if (Last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", Last); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", Done); end
    checks++; if (Ready_l !== 1'b1) begin errors++; $display("FAIL reset_ready_lsb got %b exp 1", Ready_l); end
  endtask

  // One frame on the MSB-first instance; noise pulses Valid with other data mid-frame.
  task automatic test_frame(input logic [3:0] d, input logic [4:0] exp5, input bit noise, input bit chk_sipo);
    logic [3:0] snap;
    snap = 4'h0;
    Data = d; Valid = 1'b1;
    tick();
    Valid = 1'b0;
    for (int i = 1; i <= FLEN; i++) begin
      if (noise && i == 2) begin Data = ~d; Valid = 1'b1; end
      if (noise && i == 3) Valid = 1'b0;
      checks++; if (Out !== exp5[5-i]) begin errors++; $display("FAIL frame_out d=%b cyc=%0d got %b exp %b", d, i, Out, exp5[5-i]); end
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL frame_busy d=%b cyc=%0d got %b exp 1", d, i, Busy); end
      checks++; if (Last !== (i == FLEN)) begin errors++; $display("FAIL frame_last d=%b cyc=%0d got %b exp %b", d, i, Last, (i == FLEN)); end
      checks++; if (Ready !== (i == FLEN)) begin errors++; $display("FAIL frame_ready d=%b cyc=%0d got %b exp %b", d, i, Ready, (i == FLEN)); end
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL frame_done_early d=%b cyc=%0d got %b exp 0", d, i, Done); end
      tick();
      if (i == 4) snap = sipo;
    end
    checks++; if (Done !== 1'b1) begin errors++; $display("FAIL frame_done d=%b got %b exp 1", d, Done); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL frame_idle_busy d=%b got %b exp 0", d, Busy); end
    checks++; if (Out !== 1'b0) begin errors++; $display("FAIL frame_idle_out d=%b got %b exp 0", d, Out); end
    checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL frame_idle_ready d=%b got %b exp 1", d, Ready); end
    if (chk_sipo) begin
      checks++; if (snap !== d) begin errors++; $display("FAIL loopback got %b exp %b", snap, d); end
    end
    tick();
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL frame_done_width d=%b got %b exp 0", d, Done); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] e1, e2;
    logic       expb;
    int         dones, drops;
    e1 = 5'b10111;
    e2 = 5'b01100;
    dones = 0; drops = 0;
    Data = 4'b1011; Valid = 1'b1;
    tick();
    for (int c = 1; c <= 2 * FLEN; c++) begin
      if (c == 2) Data = 4'b0101;
      if (c == FLEN) Data = 4'b0110;
      if (c == FLEN + 1) Valid = 1'b0;
      expb = (c <= FLEN) ? e1[5-c] : e2[5-(c-FLEN)];
      checks++; if (Out !== expb) begin errors++; $display("FAIL b2b_out cyc=%0d got %b exp %b", c, Out, expb); end
      checks++; if (Last !== (c == FLEN || c == 2 * FLEN)) begin errors++; $display("FAIL b2b_last cyc=%0d got %b", c, Last); end
      if (Busy !== 1'b1) drops++;
      if (Done === 1'b1) dones++;
      tick();
    end
    if (Done === 1'b1) dones++;
    checks++; if (drops != 0) begin errors++; $display("FAIL b2b_busy_drops got %0d exp 0", drops); end
    checks++; if (dones != 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", dones); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL b2b_end_busy got %b exp 0", Busy); end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    Data = 4'b1111; Valid = 1'b1;
    tick();
    Valid = 1'b0;
    tick();
    #2 Rst_n = 1'b0;
    #1;
    checks++; if (Out !== 1'b0) begin errors++; $display("FAIL abort_out got %b exp 0", Out); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", Busy); end
    checks++; if (Last !== 1'b0) begin errors++; $display("FAIL abort_last got %b exp 0", Last); end
    tick();
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", Done); end
    Rst_n = 1'b1;
    tick();
    checks++; if (Done !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL abort_after got done=%b busy=%b exp 0 0", Done, Busy); end
    test_frame(4'b1000, 5'b10001, 1'b0, 1'b0);
  endtask

  task automatic test_lsb_first();
    logic [4:0] e;
    e = 5'b11011;
    Data_l = 4'b1011; Valid_l = 1'b1;
    tick();
    Valid_l = 1'b0;
    for (int i = 1; i <= FLEN; i++) begin
      checks++; if (Out_l !== e[5-i]) begin errors++; $display("FAIL lsb_out cyc=%0d got %b exp %b", i, Out_l, e[5-i]); end
      checks++; if (Last_l !== (i == FLEN)) begin errors++; $display("FAIL lsb_last cyc=%0d got %b", i, Last_l); end
      tick();
    end
    checks++; if (Done_l !== 1'b1) begin errors++; $display("FAIL lsb_done got %b exp 1", Done_l); end
    checks++; if (Busy_l !== 1'b0) begin errors++; $display("FAIL lsb_idle_busy got %b exp 0", Busy_l); end
    tick();
  endtask

  initial begin
    Rst_n = 1'b0; Data = 4'h0; Valid = 1'b0; Data_l = 4'h0; Valid_l = 1'b0;
    #2;
    test_reset();
    tick();
    tick();
    Rst_n = 1'b1;
    tick();
    test_frame(4'b1011, 5'b10111, 1'b1, 1'b0);
    test_frame(4'b0110, 5'b01100, 1'b0, 1'b1);
    test_frame(4'b1001, 5'b10010, 1'b0, 1'b1);
    test_back_to_back();
    test_reset_mid_frame();
    test_lsb_first();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
